// File: rtl/tx_seq_pkg.sv
// Shared symbol constants, control-mux encodings and FSM state type for the
// transmit sequencer.
package tx_seq_pkg;

    localparam logic [7:0] STP = 8'hFB;
    localparam logic [7:0] SDP = 8'h5C;
    localparam logic [7:0] END = 8'hFD;
    localparam logic [7:0] EDB = 8'hFE;
    localparam logic [7:0] SKP = 8'h1C;
    localparam logic [7:0] IDL = 8'h7C;
    localparam logic [7:0] FTS = 8'h3C;
    localparam logic [7:0] COM = 8'hBC;

    localparam logic [1:0] CTRL_DATA  = 2'b00;
    localparam logic [1:0] CTRL_FRAME = 2'b01;
    localparam logic [1:0] CTRL_OS    = 2'b10;
    localparam logic [1:0] CTRL_COM   = 2'b11;

    // SKP symbols that follow the COM of a SKP ordered set.
    localparam int unsigned SKP_OS_CYCLES = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_END,
        S_SKP_COM,
        S_SKP
    } state_t;

endpackage

// File: rtl/tx_seq_ctrl_skp_timer.sv
// Free-running SKP interval timer: pulses expire once every SKP_INTERVAL
// cycles, counting from reset.
module skp_timer #(
    parameter int unsigned SKP_INTERVAL = 16
) (
    input  logic clk,
    input  logic reset,
    output logic expire
);

    localparam int unsigned CW = $clog2(SKP_INTERVAL);

    logic [CW-1:0] count_q;

    assign expire = (count_q == CW'(SKP_INTERVAL - 1));

    always_ff @(posedge clk) begin
        if (reset || expire) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CW'(1);
        end
    end

endmodule

// File: rtl/tx_seq_ctrl.sv
// Transmit framing sequencer: STP/SDP, data, END/EDB, with optional SKP
// ordered-set insertion at packet boundaries when TX_SEQ_SKP_EN is defined.
module tx_seq_ctrl
    import tx_seq_pkg::*;
#(
    parameter int unsigned SKP_INTERVAL = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pkt_req,
    input  logic       pkt_type,
    input  logic [7:0] pkt_len,
    input  logic       pkt_abort,
    output logic       pkt_ack,
    output logic       rd_en,
    output logic [1:0] control,
    output logic [7:0] start_end,
    output logic [7:0] ordered_set,
    output logic [7:0] logical_COM,
    output logic       busy
);

    if (SKP_INTERVAL < 8) begin : g_bad_interval
        $error("tx_seq_ctrl: SKP_INTERVAL must be at least 8");
    end

    state_t     state_q;
    state_t     state_d;
    state_t     boundary_next;
    logic       type_q;
    logic       aborted_q;
    logic [7:0] cnt_q;

`ifdef TX_SEQ_SKP_EN
    logic       skp_expire;
    logic       skp_pending_q;
    logic [1:0] skp_cnt_q;

    skp_timer #(
        .SKP_INTERVAL(SKP_INTERVAL)
    ) u_skp_timer (
        .clk   (clk),
        .reset (reset),
        .expire(skp_expire)
    );

    // Entering SKP_COM services every expiry seen so far.
    always_ff @(posedge clk) begin
        if (reset) begin
            skp_pending_q <= 1'b0;
            skp_cnt_q     <= '0;
        end else begin
            if (state_d == S_SKP_COM) begin
                skp_pending_q <= 1'b0;
            end else if (skp_expire) begin
                skp_pending_q <= 1'b1;
            end
            skp_cnt_q <= (state_q == S_SKP) ? skp_cnt_q + 2'd1 : 2'd0;
        end
    end
`endif

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            type_q    <= 1'b0;
            aborted_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == S_START) begin
                type_q    <= pkt_type;
                aborted_q <= 1'b0;
                cnt_q     <= (pkt_len == 8'd0) ? 8'd1 : pkt_len;
            end else if (state_q == S_DATA) begin
                cnt_q <= cnt_q - 8'd1;
                if (pkt_abort) begin
                    aborted_q <= 1'b1;
                end
            end
        end
    end

    // SKP takes priority over a waiting packet at every boundary.
    always_comb begin
        boundary_next = pkt_req ? S_START : S_IDLE;
`ifdef TX_SEQ_SKP_EN
        if (skp_pending_q) begin
            boundary_next = S_SKP_COM;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = boundary_next;
            S_START: state_d = S_DATA;
            S_DATA: begin
                if (pkt_abort || cnt_q == 8'd1) begin
                    state_d = S_END;
                end
            end
            S_END:   state_d = boundary_next;
`ifdef TX_SEQ_SKP_EN
            S_SKP_COM: state_d = S_SKP;
            S_SKP: begin
                if (skp_cnt_q == 2'(SKP_OS_CYCLES - 1)) begin
                    state_d = pkt_req ? S_START : S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        control     = CTRL_OS;
        start_end   = END;
        ordered_set = IDL;
        pkt_ack     = 1'b0;
        rd_en       = 1'b0;
        unique case (state_q)
            S_START: begin
                control   = CTRL_FRAME;
                start_end = type_q ? SDP : STP;
                pkt_ack   = 1'b1;
            end
            S_DATA: begin
                control = CTRL_DATA;
                rd_en   = 1'b1;
            end
            S_END: begin
                control   = CTRL_FRAME;
                start_end = aborted_q ? EDB : END;
            end
`ifdef TX_SEQ_SKP_EN
            S_SKP_COM: control = CTRL_COM;
            S_SKP:     ordered_set = SKP;
`endif
            default: ;
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign logical_COM = COM;

endmodule

// File: doc/tx_seq_ctrl.md
TX_SEQ_CTRL -- requirements
Module: tx_seq_ctrl

Interface
REQ-001 SHALL have parameter: SKP_INTERVAL, 16, clock cycles between SKP ordered-set insertions, minimum 8.
REQ-002 SHALL have port: clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: pkt_req  input  1  packet pending from the transmit data buffer; held high until pkt_ack.
REQ-005 SHALL have port: pkt_type  input  1  packet type, 0=TLP (STP framing), 1=DLLP (SDP framing); sampled at pkt_ack.
REQ-006 SHALL have port: pkt_len  input  8  payload bytes; sampled at pkt_ack; 0 is treated as 1.
REQ-007 SHALL have port: pkt_abort  input  1  nullify current packet; honoured only in DATA.
REQ-008 SHALL have port: pkt_ack  output  1  one-cycle pulse, packet accepted.
REQ-009 SHALL have port: rd_en  output  1  buffer byte consumed this cycle; buffer advances D_in.
REQ-010 SHALL have port: control  output  2  mux select: 00 data, 01 start/end, 10 ordered-set, 11 COM.
REQ-011 SHALL have port: start_end  output  8  framing symbol to mux.
REQ-012 SHALL have port: ordered_set  output  8  ordered-set symbol to mux.
REQ-013 SHALL have port: logical_COM  output  8  constant 8'hBC.
REQ-014 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL be a registered FSM: IDLE, START, DATA, END, SKP_COM, SKP; all outputs decoded from registered state, no combinational input-to-output path except rd_en (state-decoded only).
REQ-016 IDLE: control=10, ordered_set=IDL (8'h7C).
REQ-017 IDLE with pkt_req=1 and no SKP pending: next state START; pkt_ack pulses in the START cycle; pkt_type/pkt_len captured at that edge.
REQ-018 START (1 cycle): control=01, start_end=STP (8'hFB) for TLP or SDP (8'h5C) for DLLP; next state DATA.
REQ-019 DATA: control=00, rd_en=1, byte counter loaded with pkt_len (0 -> 1) decrements per cycle; exactly pkt_len cycles; after last byte -> END.
REQ-020 pkt_abort=1 in any DATA cycle: that cycle's byte is the last; next state END with EDB.
REQ-021 END (1 cycle): control=01, start_end=END (8'hFD) normally, EDB (8'hFE) if aborted; next IDLE, or SKP_COM if SKP pending, or START if pkt_req=1 (back-to-back, no IDL gap).
REQ-022 SKP timer counts every cycle; reaching SKP_INTERVAL-1 sets skp_pending and restarts count; pending saturates (multiple expiries collapse to one).
REQ-023 SKP insertion only at packet boundaries (IDLE or END exit); never splits a packet.
REQ-024 SKP pending and pkt_req both present: SKP ordered set first; pkt_ack deferred until return.
REQ-025 SKP_COM (1 cycle): control=11; then SKP 3 cycles: control=10, ordered_set=SKP (8'h1C); skp_pending cleared on entering SKP_COM; then IDLE/START per pkt_req.
REQ-026 Unused symbol outputs SHALL hold IDL (ordered_set) and END (start_end) when not selected.

Reset
REQ-027 reset=1 at a clock edge SHALL force IDLE, control=10, ordered_set=IDL, start_end=END, pkt_ack=0, rd_en=0, busy=0, counters and skp_pending cleared, regardless of state; mid-packet reset drops the packet with no END/EDB.

Configuration
REQ-028 Macro TX_SEQ_SKP_EN defined: SKP timer, skp_pending, SKP_COM and SKP states present per REQ-022..025.
REQ-029 TX_SEQ_SKP_EN undefined: timer and SKP states removed, control=11 never produced, END exits to START or IDLE only.

Structure
REQ-030 Package tx_seq_pkg SHALL hold symbol constants STP, SDP, END, EDB, SKP, IDL, FTS, COM, the control encodings, and the state enum.
REQ-031 SKP timer SHALL be sub-module skp_timer (SKP_INTERVAL parameter, expire pulse output), instantiated only under TX_SEQ_SKP_EN.

Verification
REQ-032 Reset, no pkt_req for 5 cycles (SKP disabled) -> control=10, ordered_set=8'h7C every cycle, busy=0.
REQ-033 TLP, pkt_len=3 -> cycles: control 01/FB, 00 x3 with rd_en=1, 01/FD, then IDL; pkt_ack in the FB cycle.
REQ-034 DLLP, pkt_len=6, pkt_abort in 2nd DATA cycle -> 01/5C, 00 x2, 01/FE, IDLE.
REQ-035 SKP_INTERVAL=16, pkt_req high continuously with pkt_len=20 -> SKP deferred to packet end: 01/FD, 11, 10/1C x3, then 01/FB; no packet split.
REQ-036 pkt_len=0 -> exactly one DATA cycle; reset asserted in DATA of a pkt_len=10 packet -> next cycle IDL, no END emitted.
